uart_receiver: RTL and testbench

Receive-side counterpart of the UART transmitter. Deserializes an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit) from the RsRx pin using 16 samples per bit on uart_samplig_clk. Delivers each good byte through a valid/ready handshake to the host logic. Flags framing errors and overruns.

---
 rtl/uart_receiver.sv | 112 +++++++++++
 tb/tb_uart_receiver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, 16x oversampled. It delivers each good byte through a valid/ready
// handshake and pulses frame_error or overrun for one cycle when a frame goes wrong.
module uart_receiver (
  input  logic       uart_samplig_clk,
  input  logic       reset,
  input  logic       RsRx,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data_out,
  output logic       frame_error,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t     state, state_nx;
  logic       sync0, rx_s;
  logic [3:0] phase, phase_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx, data_nx;
  logic       valid_nx, ferr_nx, ovr_nx;

  always_ff @(posedge uart_samplig_clk) begin
    if (!reset) begin
      sync0       <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      phase       <= 4'd0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      data_out    <= 8'h00;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync0       <= RsRx;
      rx_s        <= sync0;
      state       <= state_nx;
      phase       <= phase_nx;
      bit_cnt     <= bit_cnt_nx;
      shreg       <= shreg_nx;
      data_out    <= data_nx;
      valid       <= valid_nx;
      frame_error <= ferr_nx;
      overrun     <= ovr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    data_nx    = data_out;
    valid_nx   = valid && !ready;
    ferr_nx    = 1'b0;
    ovr_nx     = 1'b0;
    case (state)
      IDLE: begin
        phase_nx = 4'd0;
        if (!rx_s) begin
          state_nx = START;
          phase_nx = 4'd1;
        end
      end
      START: begin
        phase_nx = phase + 4'd1;
        if (phase == 4'd7) begin
          phase_nx   = 4'd0;
          bit_cnt_nx = 3'd0;
          state_nx   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        // phase wraps 15->0, so the next bit's window restarts on its own
        phase_nx = phase + 4'd1;
        if (phase == 4'd15) begin
          shreg_nx   = {rx_s, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        phase_nx = phase + 4'd1;
        if (phase == 4'd15) begin
          if (rx_s) begin
            state_nx = IDLE;
            if (!valid || ready) begin
              data_nx  = shreg;
              valid_nx = 1'b1;
            end else begin
              ovr_nx = 1'b1;
            end
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // hold off until the line returns high, so a break is not decoded as 0x00 frames
        phase_nx = 4'd0;
        if (rx_s) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        phase_nx = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver. It drives 16-cycle bits on RsRx and checks the outputs
// at fixed offsets from the start edge, plus cumulative flag and handshake counters.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset, RsRx, ready;
  logic       valid, frame_error, overrun;
  logic [7:0] data_out;

  int n_chk = 0, n_fail = 0;
  int n_fe = 0, n_ov = 0, n_acc = 0;
  logic [7:0] got[$];
  logic       cap_v, cap_fe, cap_ov, cap2_v, cap2_fe, cap2_ov;
  logic [7:0] cap_d;
  int fe0, ov0, acc0;

  uart_receiver dut (
    .uart_samplig_clk(clk),
    .reset(reset),
    .RsRx(RsRx),
    .ready(ready),
    .valid(valid),
    .data_out(data_out),
    .frame_error(frame_error),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (frame_error) n_fe++;
      if (overrun) n_ov++;
      if (valid && ready) begin
        n_acc++;
        got.push_back(data_out);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick 154 after the start edge is the first cycle valid or a flag is visible
  // (2 sync cycles + decision at t, stop sampled at t+151).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int len);
    for (int k = 0; k < len; k++) begin
      if (k < 16) RsRx = 1'b0;
      else if (k < 144) RsRx = b[(k - 16) >> 4];
      else RsRx = stop;
      tick(1);
      if (k + 1 == 154) begin
        cap_v = valid; cap_d = data_out; cap_fe = frame_error; cap_ov = overrun;
      end
      if (k + 1 == 155) begin
        cap2_v = valid; cap2_fe = frame_error; cap2_ov = overrun;
      end
    end
  endtask

  task automatic snap();
    fe0 = n_fe; ov0 = n_ov; acc0 = n_acc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  exp_lb[3];
    reset = 1'b0; RsRx = 1'b1; ready = 1'b0;
    tick(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_fe", frame_error, 0);
    chk("rst_ov", overrun, 0);
    reset = 1'b1;
    tick(5);

    // single byte, ready held high
    ready = 1'b1; snap();
    send_frame(8'hA5, 1'b1, 160);
    chk("a5_valid", cap_v, 1);
    chk("a5_data", cap_d, 8'hA5);
    chk("a5_valid_1cyc", cap2_v, 0);
    chk("a5_flags", {cap_fe, cap_ov}, 0);
    tick(10);
    chk("a5_acc", n_acc - acc0, 1);

    // 4-cycle glitch is rejected silently
    snap();
    RsRx = 1'b0; tick(4); RsRx = 1'b1; tick(40);
    chk("glitch_acc", n_acc - acc0, 0);
    chk("glitch_flags", (n_fe - fe0) + (n_ov - ov0), 0);
    chk("glitch_valid", valid, 0);

    // framing error, break held, then recovery
    snap();
    send_frame(8'h3C, 1'b0, 160);
    chk("fe_pulse", cap_fe, 1);
    chk("fe_valid", cap_v, 0);
    chk("fe_pulse_1cyc", cap2_fe, 0);
    RsRx = 1'b0; tick(40);
    RsRx = 1'b1; tick(20);
    chk("fe_count", n_fe - fe0, 1);
    chk("fe_no_acc", n_acc - acc0, 0);
    send_frame(8'h5A, 1'b1, 160);
    chk("after_fe_valid", cap_v, 1);
    chk("after_fe_data", cap_d, 8'h5A);
    tick(10);

    // back-to-back with ready low: second frame overruns
    ready = 1'b0; snap();
    send_frame(8'h11, 1'b1, 160);
    chk("b2b_first_valid", valid, 1);
    chk("b2b_first_data", data_out, 8'h11);
    send_frame(8'h22, 1'b1, 160);
    chk("ovr_pulse", cap_ov, 1);
    chk("ovr_pulse_1cyc", cap2_ov, 0);
    chk("ovr_data_kept", data_out, 8'h11);
    chk("ovr_valid_kept", valid, 1);
    chk("ovr_count", n_ov - ov0, 1);
    tick(5);
    ready = 1'b1;
    chk("accept_pre", valid, 1);
    tick(1);
    chk("accept_drop", valid, 0);
    tick(10);

    // reset during data bit 4
    snap();
    send_frame(8'h96, 1'b1, 88);
    reset = 1'b0; RsRx = 1'b1;
    tick(5);
    reset = 1'b1;
    chk("midrst_valid", valid, 0);
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_flags", {frame_error, overrun}, 0);
    tick(200);
    chk("midrst_quiet", (n_acc - acc0) + (n_fe - fe0) + (n_ov - ov0), 0);
    send_frame(8'hFF, 1'b1, 160);
    chk("post_rst_valid", cap_v, 1);
    chk("post_rst_data", cap_d, 8'hFF);
    tick(10);

    // back-to-back stream
    got.delete(); snap();
    exp_lb[0] = 8'h00; exp_lb[1] = 8'hFF; exp_lb[2] = 8'h81;
    for (int i = 0; i < 3; i++) send_frame(exp_lb[i], 1'b1, 160);
    tick(20);
    chk("lb_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      v = (got.size() > i) ? {24'h0, got[i]} : 32'hDEAD;
      chk($sformatf("lb_byte%0d", i), v, {24'h0, exp_lb[i]});
    end
    chk("lb_flags", (n_fe - fe0) + (n_ov - ov0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
